// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared debounce constants and counter-width helper.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

// Counter must hold DEBOUNCE_CYCLES-1; the extra bit keeps DEBOUNCE_CYCLES=1 at width 1.
`define BC_CNT_W(n) ($clog2(n) + 1)

package button_conditioner_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_SYNTH = 1000000;
  localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchronizer, consecutive-sample debouncer and press pulse.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYNTH
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int unsigned CNT_W = `BC_CNT_W(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             pulse_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      pulse_r <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      pulse_r <= 1'b0;
      // Any sample agreeing with the accepted level restarts the run.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable  <= s2;
        cnt     <= '0;
        pulse_r <= s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign pulse = pulse_r;
  assign level = stable;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// button_conditioner: conditions the left/right buttons into press pulses and debounced levels.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYNTH
) (
  input  logic clk,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  output logic left,
  output logic right,
  output logic left_level,
  output logic right_level
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clk  (clk),
    .reset(reset),
    .raw  (left_raw),
    .pulse(left),
    .level(left_level)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clk  (clk),
    .reset(reset),
    .raw  (right_raw),
    .pulse(right),
    .level(right_level)
  );

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_button_conditioner;

  localparam int unsigned DC  = 4;
  localparam int          LAT = DC + 2;  // negedge index offset from the drive negedge

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left_raw = 1'b1;
  logic right_raw = 1'b1;
  logic left, right, left_level, right_level;

  int ecnt = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    bit ch;  // 0 = left, 1 = right
  } ev_t;
  ev_t q[$];

  button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .left_raw   (left_raw),
    .right_raw  (right_raw),
    .left       (left),
    .right      (right),
    .left_level (left_level),
    .right_level(right_level)
  );

  always #1 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic expect_pulse(input int cyc, input bit ch);
    ev_t e;
    e.cyc = cyc;
    e.ch  = ch;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, ecnt, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_seen(input bit ch);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse ch=%0d at edge %0d: got pulse expected none", ch, ecnt);
    end else begin
      e = q.pop_front();
      if (e.ch != ch || e.cyc != ecnt) begin
        errors++;
        $display("FAIL pulse_match: got ch=%0d edge=%0d expected ch=%0d edge=%0d", ch, ecnt, e.ch, e.cyc);
      end
    end
  endtask

  // Monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < ecnt) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse ch=%0d: got none expected edge %0d", q[0].ch, q[0].cyc);
      void'(q.pop_front());
    end
    if (left === 1'b1) pulse_seen(1'b0);
    if (right === 1'b1) pulse_seen(1'b1);
  end

  initial begin
    int n;

    // Reset held with both buttons pressed.
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", {left, right, left_level, right_level}, 4'b0000);
    end
    reset = 1'b0;
    n = ecnt;
    expect_pulse(n + LAT, 1'b0);
    expect_pulse(n + LAT, 1'b1);
    tick(LAT - 1);
    chk("post_reset_levels_early", {left_level, right_level}, 4'b0000);
    tick(1);
    chk("post_reset_levels", {left_level, right_level}, 4'b0011);
    tick(4);
    left_raw = 1'b0;
    right_raw = 1'b0;
    tick(LAT - 1);
    chk("release_both_early", {left_level, right_level}, 4'b0011);
    tick(1);
    chk("release_both", {left_level, right_level}, 4'b0000);
    tick(4);

    // Clean left press held 20 cycles.
    left_raw = 1'b1;
    n = ecnt;
    expect_pulse(n + LAT, 1'b0);
    tick(LAT - 1);
    chk("clean_level_early", {left_level, right_level}, 4'b0000);
    tick(1);
    chk("clean_level", {left_level, right_level}, 4'b0010);
    tick(20 - LAT);
    left_raw = 1'b0;
    tick(LAT - 1);
    chk("clean_release_early", {left_level, right_level}, 4'b0010);
    tick(1);
    chk("clean_release", {left_level, right_level}, 4'b0000);
    tick(4);

    // Bounce 1,0,1,0,1,0 then steady high.
    for (int i = 0; i < 6; i++) begin
      left_raw = (i % 2 == 0);
      tick(1);
    end
    left_raw = 1'b1;
    n = ecnt;
    expect_pulse(n + LAT, 1'b0);
    tick(LAT - 1);
    chk("bounce_level_early", {left_level, right_level}, 4'b0000);
    tick(1);
    chk("bounce_level", {left_level, right_level}, 4'b0010);
    tick(14);
    left_raw = 1'b0;
    tick(LAT + 4);
    chk("bounce_release", {left_level, right_level}, 4'b0000);

    // Right glitches: sub-cycle pulse between edges, then 3 cycles high.
    #0.2 right_raw = 1'b1;
    #0.6 right_raw = 1'b0;
    tick(2);
    right_raw = 1'b1;
    tick(3);
    right_raw = 1'b0;
    repeat (4) begin
      tick(2);
      chk("glitch_levels", {left_level, right_level}, 4'b0000);
    end

    // Re-press left for 10 cycles.
    left_raw = 1'b1;
    n = ecnt;
    expect_pulse(n + LAT, 1'b0);
    tick(10);
    chk("repress_level", {left_level, right_level}, 4'b0010);
    left_raw = 1'b0;
    tick(LAT + 4);

    // Simultaneous press.
    left_raw = 1'b1;
    right_raw = 1'b1;
    n = ecnt;
    expect_pulse(n + LAT, 1'b0);
    expect_pulse(n + LAT, 1'b1);
    tick(LAT);
    chk("simul_levels", {left_level, right_level}, 4'b0011);
    tick(4);
    left_raw = 1'b0;
    right_raw = 1'b0;
    tick(LAT + 4);
    chk("simul_release", {left_level, right_level}, 4'b0000);

    // Reset while both counters sit at 2, buttons held through it.
    left_raw = 1'b1;
    right_raw = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(3);
    chk("midreset_levels", {left_level, right_level}, 4'b0000);
    reset = 1'b0;
    n = ecnt;
    expect_pulse(n + LAT, 1'b0);
    expect_pulse(n + LAT, 1'b1);
    tick(LAT - 1);
    chk("redebounce_early", {left_level, right_level}, 4'b0000);
    tick(1);
    chk("redebounce_levels", {left_level, right_level}, 4'b0011);
    tick(4);
    left_raw = 1'b0;
    right_raw = 1'b0;
    tick(LAT + 4);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
